multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer_pkg.sv | 12 +
 rtl/multi_timer_channel.sv | 77 +++++++
 rtl/multi_timer.sv | 59 +++++
 tb/tb_multi_timer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel down-counting timer.
package multi_timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: loadable down-counter with one-shot or auto-reload mode.
//
// state   | meaning
// --------+--------------------------------------------------------------
// CH_IDLE | count holds, ticks ignored, no expiry possible
// CH_RUN  | count decrements on each tick; terminal count expires/reloads
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             start_enable,
  input  logic [WIDTH-1:0] start_time,
  input  logic             periodic,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             active,
  output logic             expired
);

  ch_state_t        state;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // Channel state update; stop beats start, start beats tick, and both
  // strobes suppress any expiry that would have happened on this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CH_IDLE;
      count   <= '0;
      reload  <= '0;
      mode    <= MODE_ONESHOT;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (stop) begin
        state <= CH_IDLE;
        count <= '0;
      end else if (start_enable) begin
        if (start_time != '0) begin
          state  <= CH_RUN;
          count  <= start_time;
          reload <= start_time;
          mode   <= periodic;
        end else begin
          state <= CH_IDLE;
          count <= '0;
        end
      end else if (state == CH_RUN && tick) begin
        if (count > WIDTH'(1)) begin
          count <= count - WIDTH'(1);
        end else if (count == WIDTH'(1)) begin
          expired <= 1'b1;
          if (mode == MODE_PERIODIC) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= CH_IDLE;
          end
        end else begin
          // A zero count in RUN cannot be loaded; fall back to IDLE rather
          // than wrap.
          state <= CH_IDLE;
        end
      end
    end
  end

  // Active is a pure decode of the registered state.
  always_comb begin
    active = (state == CH_RUN);
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: one free-running prescaler feeding CHANNELS
// independent down-counting channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       start_enable,
  input  logic [CHANNELS*WIDTH-1:0] start_time,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [CHANNELS*WIDTH-1:0] timer,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       expired
);

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      tick;

  // Compare with >= so that lowering prescale mid-count never strands the
  // counter above the new terminal value.
  always_comb begin
    tick = (pre_cnt >= prescale);
  end

  // Free-running prescaler; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .tick        (tick),
      .start_enable(start_enable[n]),
      .start_time  (start_time[n*WIDTH +: WIDTH]),
      .periodic    (periodic[n]),
      .stop        (stop[n]),
      .count       (timer[n*WIDTH +: WIDTH]),
      .active      (active[n]),
      .expired     (expired[n])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer with a behavioural reference model.
module tb_multi_timer;

  localparam int W  = 10;
  localparam int CH = 4;
  localparam int PW = 8;

  logic              clk;
  logic              resetn;
  logic [CH-1:0]     start_enable;
  logic [CH*W-1:0]   start_time;
  logic [CH-1:0]     periodic;
  logic [CH-1:0]     stop;
  logic [PW-1:0]     prescale;
  logic [CH*W-1:0]   timer;
  logic [CH-1:0]     active;
  logic [CH-1:0]     expired;

  int total;
  int bad;

  // reference model state
  int m_pre;
  int m_cnt [CH];
  int m_rel [CH];
  bit m_run [CH];
  bit m_per [CH];
  bit m_exp [CH];

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_enable(start_enable),
    .start_time  (start_time),
    .periodic    (periodic),
    .stop        (stop),
    .prescale    (prescale),
    .timer       (timer),
    .active      (active),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pre = 0;
    for (int n = 0; n < CH; n++) begin
      m_cnt[n] = 0; m_rel[n] = 0; m_run[n] = 0; m_per[n] = 0; m_exp[n] = 0;
    end
  endtask

  // One clock of the behavioural model, using the inputs present at the edge.
  task automatic model_clock();
    bit tk;
    int sv;
    if (!resetn) begin
      model_reset();
      return;
    end
    tk = (m_pre >= int'(prescale));
    m_pre = tk ? 0 : m_pre + 1;
    for (int n = 0; n < CH; n++) begin
      m_exp[n] = 0;
      sv = int'(start_time[n*W +: W]);
      if (stop[n]) begin
        m_run[n] = 0; m_cnt[n] = 0;
      end else if (start_enable[n]) begin
        if (sv != 0) begin
          m_cnt[n] = sv; m_rel[n] = sv; m_per[n] = periodic[n]; m_run[n] = 1;
        end else begin
          m_cnt[n] = 0; m_run[n] = 0;
        end
      end else if (m_run[n] && tk) begin
        m_cnt[n] = m_cnt[n] - 1;
        if (m_cnt[n] == 0) begin
          m_exp[n] = 1;
          if (m_per[n]) m_cnt[n] = m_rel[n];
          else m_run[n] = 0;
        end
      end
    end
  endtask

  function automatic logic [CH*W-1:0] exp_timer();
    logic [CH*W-1:0] v;
    for (int n = 0; n < CH; n++) v[n*W +: W] = W'(m_cnt[n]);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_active();
    logic [CH-1:0] v;
    for (int n = 0; n < CH; n++) v[n] = m_run[n];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_expired();
    logic [CH-1:0] v;
    for (int n = 0; n < CH; n++) v[n] = m_exp[n];
    return v;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick_clk();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_strobes();
    start_enable = '0;
    stop         = '0;
  endtask

  task automatic quiesce();
    stop = '1;
    tick_clk();
    clear_strobes();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_strobes();
    start_time = '0;
    periodic   = '0;
    prescale   = '0;
    model_reset();
    tick_clk();
    tick_clk();
    total++;
    if (timer !== '0 || active !== '0 || expired !== '0) begin
      bad++;
      $display("FAIL reset_outputs: timer=%h active=%b expired=%b want all 0", timer, active, expired);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_oneshot();
    int tv;
    prescale = 0;
    start_time[0 +: W] = W'(5);
    periodic[0] = 1'b0;
    start_enable[0] = 1'b1;
    tick_clk();
    clear_strobes();
    for (int k = 0; k < 7; k++) begin
      tv = (k <= 5) ? 5 - k : 0;
      total++;
      if (timer[0 +: W] !== W'(tv) || active[0] !== (k < 5) || expired[0] !== (k == 5)) begin
        bad++;
        $display("FAIL oneshot_seq k=%0d: timer=%0d act=%b exp=%b want %0d %b %b", k, timer[0 +: W], active[0], expired[0], tv, k < 5, k == 5);
      end
      total++;
      if (timer !== exp_timer() || expired !== exp_expired()) begin
        bad++;
        $display("FAIL oneshot_model k=%0d: timer=%h exp=%b want %h %b", k, timer, expired, exp_timer(), exp_expired());
      end
      tick_clk();
    end
  endtask

  task automatic test_periodic();
    int pulses;
    prescale = 2;
    start_time[W +: W] = W'(3);
    periodic[1] = 1'b1;
    start_enable[1] = 1'b1;
    tick_clk();
    clear_strobes();
    pulses = 0;
    for (int k = 0; k < 36; k++) begin
      total++;
      if (timer !== exp_timer() || active !== exp_active() || expired !== exp_expired()) begin
        bad++;
        $display("FAIL periodic k=%0d: timer=%h act=%b exp=%b want %h %b %b", k, timer, active, expired, exp_timer(), exp_active(), exp_expired());
      end
      if (active[1] !== 1'b1) begin
        bad++;
        $display("FAIL periodic_active k=%0d: got %b want 1", k, active[1]);
      end
      tick_clk();
      if (expired[1] === 1'b1) pulses++;
    end
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL periodic_pulses: got %0d want 4", pulses);
    end
    quiesce();
  endtask

  task automatic stop_restart_case(input bit use_start);
    int guard;
    prescale = 0;
    start_time[2*W +: W] = W'(4);
    periodic[2] = 1'b0;
    start_enable[2] = 1'b1;
    tick_clk();
    clear_strobes();
    guard = 0;
    while (timer[2*W +: W] !== W'(1) && guard < 50) begin
      tick_clk();
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++;
      $display("FAIL stop_wait: timer2 never reached 1, got %0d", timer[2*W +: W]);
    end
    if (use_start) begin
      start_time[2*W +: W] = W'(7);
      start_enable[2] = 1'b1;
    end else begin
      stop[2] = 1'b1;
    end
    tick_clk();
    clear_strobes();
    total++;
    if (timer[2*W +: W] !== W'(use_start ? 7 : 0) || active[2] !== use_start || expired[2] !== 1'b0) begin
      bad++;
      $display("FAIL %s_at_terminal: timer=%0d act=%b exp=%b want %0d %b 0", use_start ? "start" : "stop", timer[2*W +: W], active[2], expired[2], use_start ? 7 : 0, use_start);
    end
    total++;
    if (timer !== exp_timer() || active !== exp_active() || expired !== exp_expired()) begin
      bad++;
      $display("FAIL stop_model: timer=%h act=%b exp=%b want %h %b %b", timer, active, expired, exp_timer(), exp_active(), exp_expired());
    end
    quiesce();
  endtask

  task automatic test_stop_restart();
    stop_restart_case(1'b0);
    stop_restart_case(1'b1);
  endtask

  task automatic test_zero_start();
    prescale = 0;
    start_time[3*W +: W] = '0;
    start_enable[3] = 1'b1;
    tick_clk();
    clear_strobes();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (timer[3*W +: W] !== '0 || active[3] !== 1'b0 || expired[3] !== 1'b0) begin
        bad++;
        $display("FAIL zero_start k=%0d: timer=%0d act=%b exp=%b want 0 0 0", k, timer[3*W +: W], active[3], expired[3]);
      end
      tick_clk();
    end
  endtask

  task automatic test_async_reset();
    prescale = 0;
    for (int n = 0; n < CH; n++) start_time[n*W +: W] = W'(2 + n);
    periodic = 4'b1010;
    start_enable = '1;
    tick_clk();
    clear_strobes();
    tick_clk();
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    total++;
    if (timer !== '0 || active !== '0 || expired !== '0) begin
      bad++;
      $display("FAIL async_reset_immediate: timer=%h act=%b exp=%b want all 0", timer, active, expired);
    end
    prescale = 3;
    tick_clk();
    tick_clk();
    total++;
    if (timer !== '0 || active !== '0 || expired !== '0) begin
      bad++;
      $display("FAIL async_reset_held: timer=%h act=%b exp=%b want all 0", timer, active, expired);
    end
    @(negedge clk);
    resetn = 1'b1;
    start_time[0 +: W] = W'(1);
    periodic[0] = 1'b0;
    start_enable[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick_clk();
      clear_strobes();
      total++;
      if (expired[0] !== (i == 4) || expired[3:1] !== 3'b000) begin
        bad++;
        $display("FAIL reset_prescaler_restart edge=%0d: exp=%b want ch0=%b", i, expired, i == 4);
      end
    end
  endtask

  task automatic test_staggered();
    int when [CH];
    prescale = 1;
    for (int n = 0; n < CH; n++) begin
      start_time[n*W +: W] = W'(n + 1);
      when[n] = -1;
    end
    periodic = '0;
    start_enable = '1;
    tick_clk();
    clear_strobes();
    for (int k = 0; k < 40; k++) begin
      for (int n = 0; n < CH; n++) if (expired[n] === 1'b1 && when[n] < 0) when[n] = k;
      total++;
      if (timer !== exp_timer() || expired !== exp_expired()) begin
        bad++;
        $display("FAIL stagger_model k=%0d: timer=%h exp=%b want %h %b", k, timer, expired, exp_timer(), exp_expired());
      end
      tick_clk();
    end
    for (int n = 1; n < CH; n++) begin
      total++;
      if (when[0] < 0 || when[n] != when[n-1] + 2) begin
        bad++;
        $display("FAIL stagger_order ch%0d: pulse at %0d want %0d", n, when[n], when[n-1] + 2);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 3));
      for (int n = 0; n < CH; n++) begin
        start_enable[n] = ($urandom_range(0, 7) == 0);
        stop[n]         = ($urandom_range(0, 19) == 0);
        periodic[n]     = $urandom_range(0, 1) == 1;
        start_time[n*W +: W] = W'($urandom_range(0, 6));
      end
      tick_clk();
      clear_strobes();
      total++;
      if (timer !== exp_timer() || active !== exp_active() || expired !== exp_expired()) begin
        bad++;
        $display("FAIL random k=%0d: timer=%h act=%b exp=%b want %h %b %b", k, timer, active, expired, exp_timer(), exp_active(), exp_expired());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_restart();
    test_zero_start();
    test_async_reset();
    quiesce();
    test_staggered();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
